// File: rtl/nth_root_pkg.sv
// Shared types and width helpers for the iterative fixed-point N-th root block.
package nth_root_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, POW, CMP, DONE} state_t;

  function automatic int calc_nmax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int calc_out_w(input int rad_w, input int frac_w);
    return rad_w + frac_w;
  endfunction

  // Target X<<(N*FRAC_W) must fit for the largest N.
  function automatic int calc_acc_w(input int rad_w, input int exp_w, input int frac_w);
    return rad_w + calc_nmax(exp_w) * frac_w;
  endfunction

endpackage

// File: rtl/nth_root_pow_step.sv
// One power step: partial*guess at full width, so the comparison against the target never wraps.
module nth_root_pow_step
  import nth_root_pkg::*;
#(
  parameter int ACC_W = calc_acc_w(10, 3, 10),
  parameter int OUT_W = calc_out_w(10, 10)
) (
  input  logic [ACC_W-1:0] partial,
  input  logic [OUT_W-1:0] guess,
  input  logic [ACC_W-1:0] target,
  output logic [ACC_W-1:0] product,
  output logic             over
);

  localparam int PROD_W = ACC_W + OUT_W;

  logic [PROD_W-1:0] full;

  assign full    = PROD_W'(partial) * PROD_W'(guess);
  assign over    = full > PROD_W'(target);
  assign product = full[ACC_W-1:0];

endmodule

// File: rtl/nth_root_iter.sv
// Bit-serial N-th root: one result bit per trial, guess^N built by sequential multiplies.
module nth_root_iter
  import nth_root_pkg::*;
#(
  parameter int RAD_W  = 10,
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RAD_W-1:0]        in_data_1,
  input  logic [EXP_W-1:0]        in_data_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RAD_W+FRAC_W-1:0] out_data,
  output logic                    out_err
);

  localparam int OUT_W = calc_out_w(RAD_W, FRAC_W);
  localparam int ACC_W = calc_acc_w(RAD_W, EXP_W, FRAC_W);
  localparam logic [OUT_W-1:0] MSB_BIT = {1'b1, {(OUT_W-1){1'b0}}};

  state_t           state, next_state;
  logic [RAD_W-1:0] x_q;
  logic [EXP_W-1:0] n_q, mul_left;
  logic [ACC_W-1:0] target, partial, product;
  logic [OUT_W-1:0] result, trial_bit, guess, next_result, next_bit;
  logic             over_q, step_over, accept, power_gt, power_eq;

  assign accept      = in_valid && in_ready;
  assign guess       = result | trial_bit;
  assign next_bit    = trial_bit >> 1;
  assign power_gt    = over_q || (partial > target);
  assign power_eq    = !over_q && (partial == target);
  assign next_result = power_gt ? result : guess;
  assign out_data    = result;

  nth_root_pow_step #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_step (
    .partial(partial),
    .guess  (guess),
    .target (target),
    .product(product),
    .over   (step_over)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (in_data_2 == '0) ? DONE : LOAD;
      LOAD: next_state = (n_q == EXP_W'(1)) ? CMP : POW;
      POW:  if (step_over || mul_left == EXP_W'(1)) next_state = CMP;
      CMP: begin
        if (power_eq || trial_bit[0]) next_state = DONE;
        else if (n_q == EXP_W'(1))    next_state = CMP;
        else                          next_state = POW;
      end
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Each trial restarts the power chain from the next guess, so partial is
  // seeded with guess itself and N-1 multiplies remain.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      x_q       <= '0;
      n_q       <= '0;
      mul_left  <= '0;
      target    <= '0;
      partial   <= '0;
      result    <= '0;
      trial_bit <= '0;
      over_q    <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      case (state)
        IDLE: if (accept) begin
          x_q     <= in_data_1;
          n_q     <= in_data_2;
          result  <= '0;
          partial <= '0;
          over_q  <= 1'b0;
          out_err <= (in_data_2 == '0);
        end
        LOAD: begin
          target    <= ACC_W'(x_q) << (FRAC_W * int'(n_q));
          result    <= '0;
          trial_bit <= MSB_BIT;
          partial   <= ACC_W'(MSB_BIT);
          mul_left  <= n_q - EXP_W'(1);
          over_q    <= 1'b0;
        end
        POW: begin
          partial  <= product;
          over_q   <= step_over;
          mul_left <= mul_left - EXP_W'(1);
        end
        CMP: begin
          result    <= next_result;
          trial_bit <= next_bit;
          partial   <= ACC_W'(next_result | next_bit);
          mul_left  <= n_q - EXP_W'(1);
          over_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nth_root_iter.sv
// Randomised and directed checks of nth_root_iter against a binary-search root model.
module tb_nth_root_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  nth_root_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data_1(in_data_1),
    .in_data_2(in_data_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  // Largest r with r^N <= X*2^(10N), found by plain binary search.
  function automatic logic [19:0] model_root(input int x, input int n);
    logic [159:0] t, p;
    logic [20:0]  lo, hi, mid;
    t  = 160'(x) << (n * 10);
    lo = '0;
    hi = 21'h100000;
    while (hi - lo > 21'd1) begin
      mid = (lo + hi) >> 1;
      p = 160'd1;
      for (int i = 0; i < n; i++) p = p * 160'(mid);
      if (p <= t) lo = mid;
      else        hi = mid;
    end
    return lo[19:0];
  endfunction

  task automatic do_req(input logic [9:0] x, input logic [2:0] n,
                        output logic [19:0] data, output logic err,
                        output int lat, output bit timed_out);
    int cyc;
    timed_out = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) timed_out = 1'b1;
    in_valid  = 1'b1;
    in_data_1 = x;
    in_data_2 = n;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data_1 = 10'($urandom);
    in_data_2 = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    data = out_data;
    err  = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 20'd0) $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_known();
    int xs[5] = '{8, 2, 1023, 27, 0};
    int ns[5] = '{3, 2, 1, 3, 5};
    int ex[5] = '{2048, 1448, 1047552, 3072, 0};
    logic [19:0] d; logic e; int lat; bit to;
    for (int k = 0; k < 5; k++) begin
      do_req(10'(xs[k]), 3'(ns[k]), d, e, lat, to);
      total_cnt++; if (to) $display("[TB] FAIL known_timeout: X=%0d N=%0d timed out", xs[k], ns[k]); else pass_cnt++;
      total_cnt++; if (d !== 20'(ex[k])) $display("[TB] FAIL known_data: X=%0d N=%0d got %0d expected %0d", xs[k], ns[k], d, ex[k]); else pass_cnt++;
      total_cnt++; if (e !== 1'b0) $display("[TB] FAIL known_err: X=%0d N=%0d got %b expected 0", xs[k], ns[k], e); else pass_cnt++;
      total_cnt++; if (lat > 20 * ns[k] + 2) $display("[TB] FAIL known_latency: X=%0d N=%0d got %0d limit %0d", xs[k], ns[k], lat, 20 * ns[k] + 2); else pass_cnt++;
      // An exact cube at bit 11 must stop before walking the 11 lower trials.
      if (k == 0) begin
        total_cnt++; if (lat >= 40) $display("[TB] FAIL exact_exit_latency: got %0d expected below 40", lat); else pass_cnt++;
      end
    end
  endtask

  task automatic test_n_zero();
    logic [19:0] d; logic e; int lat; bit to;
    do_req(10'd5, 3'd0, d, e, lat, to);
    total_cnt++; if (to) $display("[TB] FAIL nzero_timeout: timed out"); else pass_cnt++;
    total_cnt++; if (e !== 1'b1) $display("[TB] FAIL nzero_err: got %b expected 1", e); else pass_cnt++;
    total_cnt++; if (d !== 20'd0) $display("[TB] FAIL nzero_data: got %0d expected 0", d); else pass_cnt++;
    total_cnt++; if (lat > 2) $display("[TB] FAIL nzero_latency: got %0d limit 2", lat); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_d;
    int cyc = 0;
    int busy_ready = 0;
    exp_d = model_root(100, 2);
    while (!in_ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b1; in_data_1 = 10'd100; in_data_2 = 3'd2;
    @(posedge clk); #1;
    in_data_1 = 10'd7; in_data_2 = 3'd1;
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      if (in_ready !== 1'b0) busy_ready++;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    total_cnt++; if (busy_ready != 0) $display("[TB] FAIL busy_in_ready: high on %0d cycles expected 0", busy_ready); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid: cycle %0d got %b expected 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== exp_d) $display("[TB] FAIL hold_data: cycle %0d got %0d expected %0d", i, out_data, exp_d); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL release_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pow();
    logic [19:0] d; logic e; int lat; bit to;
    int cyc = 0;
    while (!in_ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b1; in_data_1 = 10'd1000; in_data_2 = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 20'd0) $display("[TB] FAIL midrst_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL midrst_ready: got %b expected 0", in_ready); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_idle: got %b expected 1", in_ready); else pass_cnt++;
    do_req(10'd27, 3'd3, d, e, lat, to);
    total_cnt++; if (to || d !== 20'd3072) $display("[TB] FAIL after_rst_data: got %0d expected 3072 (timeout %0b)", d, to); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [19:0] d, exp_d; logic e; int lat; bit to;
    int x, n;
    for (int k = 0; k < 24; k++) begin
      x = int'($urandom_range(0, 1023));
      n = int'($urandom_range(1, 7));
      exp_d = model_root(x, n);
      do_req(10'(x), 3'(n), d, e, lat, to);
      total_cnt++; if (to || d !== exp_d || e !== 1'b0)
        $display("[TB] FAIL rand_result: X=%0d N=%0d got %0d err %b expected %0d err 0 (timeout %0b)", x, n, d, e, exp_d, to);
      else pass_cnt++;
      total_cnt++; if (lat > 20 * n + 2) $display("[TB] FAIL rand_latency: X=%0d N=%0d got %0d limit %0d", x, n, lat, 20 * n + 2); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_n_zero();
    test_backpressure();
    test_reset_mid_pow();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nth_root_iter.md
NTH_ROOT_ITER -- requirements
Module: nth_root_iter

Interface
REQ-001 SHALL have parameter RAD_W, default 10, radicand width (unsigned integer).
REQ-002 SHALL have parameter EXP_W, default 3, exponent width; NMAX = 2^EXP_W-1.
REQ-003 SHALL have parameter FRAC_W, default 10, fractional bits of result; OUT_W = RAD_W+FRAC_W (20 at defaults).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept request.
REQ-008 SHALL have port in_data_1  input  RAD_W  radicand X.
REQ-009 SHALL have port in_data_2  input  EXP_W  root order N.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  OUT_W  result, unsigned fixed point, FRAC_W fraction bits.
REQ-013 SHALL have port out_err  output  1  request invalid (N=0).

Function
REQ-014 SHALL compute out_data = floor((X*2^(N*FRAC_W))^(1/N)), bit-exact.
REQ-015 SHALL accept a request on the cycle in_valid && in_ready; X, N captured then; inputs ignored otherwise.
REQ-016 SHALL assert in_ready only in IDLE; no request queuing.
REQ-017 SHALL use states IDLE, LOAD, POW, CMP, DONE.
REQ-018 IDLE->LOAD on accept; LOAD: target T = X<<(N*FRAC_W) in ACC_W = RAD_W+NMAX*FRAC_W bits, result=0, trial bit=MSB of OUT_W.
REQ-019 Per trial bit: guess = result|bit; POW computes guess^N by N-1 sequential multiplies, one per cycle; N=1 skips POW.
REQ-020 POW SHALL abort to CMP with "over" flag as soon as partial product exceeds T; products SHALL NOT wrap (saturating compare at ACC_W+OUT_W).
REQ-021 CMP: power<T -> keep bit; power==T -> keep bit, go DONE (exact-match early exit); power>T -> drop bit; then shift bit right; bit exhausted -> DONE.
REQ-022 Worst-case latency accept->out_valid SHALL be <= OUT_W*N+2 cycles.
REQ-023 N=0 SHALL go IDLE->DONE next cycle with out_err=1, out_data=0.
REQ-024 X=0 SHALL yield out_data=0, out_err=0, via normal iteration.
REQ-025 DONE: out_valid=1, out_data/out_err stable until out_ready; DONE->IDLE on out_valid&&out_ready; in_ready rises the following cycle.
REQ-026 out_valid SHALL be a register; no combinational path from any input to any output.

Reset
REQ-027 rst SHALL, at any state including mid-POW, return to IDLE next edge, aborting the operation.
REQ-028 Reset values: out_valid=0, out_data=0, out_err=0, in_ready=0 during rst, 1 the cycle after.
REQ-029 Internal accumulators SHALL be cleared on rst and on entry to LOAD.

Structure
REQ-030 Shared package nth_root_pkg SHALL hold state enum, ACC_W/OUT_W derivation functions and NMAX.
REQ-031 Sub-module nth_root_pow_step SHALL implement one saturating multiply-and-compare step (partial*guess vs T, over flag).
REQ-032 Top SHALL contain FSM, result/bit registers, handshake; 120-400 RTL lines total.

Verification
REQ-033 X=8, N=3 -> out_data=2048 (2.0), out_err=0, exact-match exit before LSB trial.
REQ-034 X=2, N=2 -> out_data=1448; X=1023, N=1 -> out_data=1047552.
REQ-035 N=0, X=5 -> out_valid with out_err=1, out_data=0 within 2 cycles; X=0, N=5 -> out_data=0.
REQ-036 out_ready low 5 cycles after out_valid -> out_data/out_valid stable; in_valid during busy ignored, in_ready=0.
REQ-037 rst pulsed mid-POW (X=1000, N=7) -> IDLE, outputs zero; next request X=27, N=3 -> out_data=3072.
REQ-038 Random X, N in 1..7 vs golden model -> bit-exact, latency <= OUT_W*N+2.
